dp_ram_ctrl: RTL
================

# dp_ram_ctrl

Parametrised true dual-port synchronous RAM for the datapath's sample and coefficient buffers, and the next generation of the team's fixed 1024x8 dual-port memory. It adds configurable width and depth, a selectable read-during-write mode, an optional output register, per-port read-valid strobes and write-collision arbitration with a saturating event counter. A hardware clear sequencer sweeps the array to a known value after reset or on request.

## Interface
- DATA_W, 8, data word width in bits.
- ADDR_W, 10, address width in bits.
- DEPTH, 1024, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- RD_MODE, 0, same-port read-during-write behaviour: 0 = read-first (old data), 1 = write-first (new data).
- OUT_REG, 0, 1 adds an output pipeline register to both ports.
- CLEAR_ON_RESET, 1, 1 starts a clear sweep automatically on reset.
- INIT_VALUE, 0, DATA_W-bit value written by the clear sweep.
- CNT_W, 8, collision counter width.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_a / en_b  in  1  port access request.
- we_a / we_b  in  1  write when en=1; read when we=0.
- addr_a / addr_b  in  ADDR_W  word address.
- din_a / din_b  in  DATA_W  write data.
- dout_a / dout_b  out  DATA_W  read data; reset value 0.
- rvalid_a / rvalid_b  out  1  one-cycle strobe marking valid dout; reset value 0.
- clear_req  in  1  single-cycle pulse that requests a clear sweep.
- busy  out  1  high while the clear sweep runs; reset value = CLEAR_ON_RESET.
- collision  out  1  one-cycle pulse on a write-write collision; reset value 0.
- coll_count  out  CNT_W  saturating count of collisions; reset value 0.

## Operation
- **Accepted access:** en=1 and busy=0. Accesses requested while busy=1 are dropped: no write occurs and no rvalid is raised.
- **rvalid:** raised for every accepted access, read or write.
- **Same-port read-during-write:** dout follows RD_MODE.
- **Cross-port access:** cross-port read of an address being written in the same cycle is always read-first (returns old data).
- **Out-of-range address (addr >= DEPTH):**
  - Writes are discarded.
  - Reads return 0 and still assert rvalid.
- **Write-write collision:** both ports accepted, both writing, same in-range address.
  - Port A's data is stored.
  - collision pulses on the next cycle.
  - coll_count increments, holding at 2**CNT_W-1.
- **Other same-address cases:** read-read is legal and does not count as a collision.
- **dout hold:** dout holds its last value between accesses.
- **Clear FSM states:** IDLE and CLEAR.
  - While rst_n is low, the FSM is held in CLEAR with ptr=0 if CLEAR_ON_RESET=1, otherwise in IDLE.
  - IDLE -> CLEAR when clear_req=1; ptr is loaded with 0.
  - In CLEAR, each cycle writes INIT_VALUE to mem[ptr] and increments ptr.
  - When ptr==DEPTH-1, that final word is written and the FSM moves CLEAR -> IDLE on the next edge.
  - clear_req asserted during CLEAR is ignored; it does not restart the sweep.
  - busy = (state==CLEAR).
- **Reset mid-sweep:** the sweep restarts from ptr=0 if CLEAR_ON_RESET=1, otherwise it is abandoned.
- **Memory contents:** the array itself is not reset.

## Timing
- **Read latency:** L = 1 + OUT_REG cycles from the accepting edge to dout/rvalid.
  - OUT_REG=0: data and rvalid are valid in the cycle after the accepting edge.
  - OUT_REG=1: they appear one cycle later.
- **Throughput:** one access per port per cycle, with no back-pressure.
- **Clear sweep duration:** exactly DEPTH cycles with busy=1.
  - Reads accepted on the cycle of clear_req still complete and produce rvalid L cycles later.
  - The first access accepted after the sweep sees INIT_VALUE at every address.
- **Clear start:** clear_req sampled on edge N gives busy=1 from edge N onward and blocks accesses presented at edge N+1.
- **Release:** after rst_n rises with CLEAR_ON_RESET=1, busy falls DEPTH cycles later.
- **Reset of registers:** all output registers and pipeline registers clear asynchronously when rst_n=0.

## Test plan
- **Reset and auto-clear:** DEPTH=16, INIT_VALUE=8'hA5, rst_n released.
  - busy is high for 16 cycles.
  - Reads of addresses 0..15 then all return 8'hA5 with rvalid after L cycles.
- **Back-to-back streaming:** OUT_REG=0 and 1. Write 0..255 at addresses 0..255 on A while B reads addresses trailing by 2.
  - Data matches, L=1 or 2 respectively, with one rvalid per access.
- **Write-write collision:** A writes 8'h11 and B writes 8'h22 to address 5 in the same cycle.
  - Readback returns 8'h11.
  - collision pulses once and coll_count=1.
  - Repeated 300 times with CNT_W=8, coll_count saturates at 255.
- **Read-during-write:** address 3 holds 8'h00, then A writes 8'h7F to address 3.
  - dout_a = 8'h00 with RD_MODE=0 and 8'h7F with RD_MODE=1.
  - A concurrent read of address 3 on B returns 8'h00 in both modes.
- **Mid-traffic clear:** pulse clear_req during random traffic, then pulse it again mid-sweep.
  - Accesses during busy produce no rvalid and no writes.
  - The sweep length stays DEPTH cycles; the second pulse does not restart it.
- **Reset mid-sweep and out-of-range:** pull rst_n low at ptr=7; the sweep restarts from 0.
  - A write to address DEPTH is dropped.
  - A read of address DEPTH returns 0 with rvalid.

Source files
------------

// File: rtl/dp_ram_ctrl.sv
// dp_ram_ctrl: parametrised true dual-port synchronous RAM with selectable
// read-during-write mode, optional output register, per-port read-valid
// strobes, write-collision arbitration with a saturating event counter and
// a hardware clear sequencer that sweeps the array to INIT_VALUE.
module dp_ram_ctrl #(
    parameter int unsigned       DATA_W         = 8,
    parameter int unsigned       ADDR_W         = 10,
    parameter int unsigned       DEPTH          = 1024,
    parameter int unsigned       RD_MODE        = 0,
    parameter int unsigned       OUT_REG        = 0,
    parameter int unsigned       CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE     = '0,
    parameter int unsigned       CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // port A
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    output logic              rvalid_a,
    // port B
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              rvalid_b,
    // clear sequencer and collision reporting
    input  logic              clear_req,
    output logic              busy,
    output logic              collision,
    output logic [CNT_W-1:0]  coll_count
);

    // Array index width; addresses at or above DEPTH never reach the array.
    localparam int unsigned       IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT   = (ADDR_W + 1)'(DEPTH);
    localparam bit                WRITE_FIRST = (RD_MODE != 0);

    // Clear sequencer states.
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;
    localparam logic [0:0] S_RESET = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;

    logic              acc_a, acc_b;
    logic              in_a, in_b;
    logic [IDX_W-1:0]  idx_a, idx_b;
    logic              wr_a, wr_b, wr_b_eff;
    logic              coll_hit;

    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              rv_a_q, rv_a_d;
    logic              rv_b_q, rv_b_d;

    logic              collision_q, collision_d;
    logic [CNT_W-1:0]  coll_count_q, coll_count_d;

    assign busy = (state_q == S_CLEAR);

    // Access decode: acceptance, range check and write-write arbitration.
    always_comb begin
        acc_a    = en_a & ~busy;
        acc_b    = en_b & ~busy;
        in_a     = ({1'b0, addr_a} < DEPTH_EXT);
        in_b     = ({1'b0, addr_b} < DEPTH_EXT);
        idx_a    = addr_a[IDX_W-1:0];
        idx_b    = addr_b[IDX_W-1:0];
        wr_a     = acc_a & we_a & in_a;
        wr_b     = acc_b & we_b & in_b;
        // Both ports writing the same word: port A wins, port B is dropped.
        coll_hit = wr_a & wr_b & (addr_a == addr_b);
        wr_b_eff = wr_b & ~coll_hit;
    end

    // Clear sequencer next-state: IDLE waits for a request, CLEAR walks ptr
    // from 0 to DEPTH-1 and returns to IDLE after the last word.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned; otherwise a latch is inferred.
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            S_CLEAR: begin
                // Requests arriving mid-sweep are ignored.
                if (ptr_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Clear sequencer state; reset either parks it in CLEAR at word 0 or in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the pre-edge values regardless of block order.
        if (!rst_n) begin
            state_q <= S_RESET;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Array write port: the sweep owns the array while busy, since no user
    // access is accepted then; otherwise A and B write independently.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; its contents are defined by
        // the clear sweep, which keeps it mappable onto block RAM.
        if (busy) begin
            mem[ptr_q] <= INIT_VALUE;
        end else begin
            if (wr_b_eff) mem[idx_b] <= din_b;
            if (wr_a)     mem[idx_a] <= din_a;
        end
    end

    // First read stage: capture old data (read-first) or the word being
    // stored this cycle (write-first); out-of-range accesses read as zero.
    // Cross-port reads always see the pre-write contents of the array.
    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        rv_a_d    = acc_a;
        rv_b_d    = acc_b;
        if (acc_a) begin
            if (!in_a) begin
                rdata_a_d = '0;
            end else if (we_a && WRITE_FIRST) begin
                rdata_a_d = din_a;
            end else begin
                rdata_a_d = mem[idx_a];
            end
        end
        if (acc_b) begin
            if (!in_b) begin
                rdata_b_d = '0;
            end else if (we_b && WRITE_FIRST) begin
                // A losing write-first port reports what the array now holds.
                rdata_b_d = coll_hit ? din_a : din_b;
            end else begin
                rdata_b_d = mem[idx_b];
            end
        end
    end

    // First read stage registers; data holds between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            rv_a_q    <= 1'b0;
            rv_b_q    <= 1'b0;
        end else begin
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            rv_a_q    <= rv_a_d;
            rv_b_q    <= rv_b_d;
        end
    end

    // Collision pulse and saturating collision counter next-state.
    always_comb begin
        collision_d  = coll_hit;
        coll_count_d = coll_count_q;
        if (coll_hit && (coll_count_q != '1)) begin
            coll_count_d = coll_count_q + 1'b1;
        end
    end

    // Collision reporting registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_q  <= 1'b0;
            coll_count_q <= '0;
        end else begin
            collision_q  <= collision_d;
            coll_count_q <= coll_count_d;
        end
    end

    assign collision  = collision_q;
    assign coll_count = coll_count_q;

    // Optional output pipeline stage, identical on both ports.
    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] dout_a_q, dout_b_q;
        logic              rvalid_a_q, rvalid_b_q;

        // Second read stage: a plain delay of the first stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_a_q   <= '0;
                dout_b_q   <= '0;
                rvalid_a_q <= 1'b0;
                rvalid_b_q <= 1'b0;
            end else begin
                dout_a_q   <= rdata_a_q;
                dout_b_q   <= rdata_b_q;
                rvalid_a_q <= rv_a_q;
                rvalid_b_q <= rv_b_q;
            end
        end

        assign dout_a   = dout_a_q;
        assign dout_b   = dout_b_q;
        assign rvalid_a = rvalid_a_q;
        assign rvalid_b = rvalid_b_q;
    end else begin : g_no_out_reg
        assign dout_a   = rdata_a_q;
        assign dout_b   = rdata_b_q;
        assign rvalid_a = rv_a_q;
        assign rvalid_b = rv_b_q;
    end

endmodule
